// File: rtl/pipeline_pkg.sv
// Shared encodings for the RV32 pipeline: ALU operations, opcodes, branch
// funct3 codes, forward selects and the execute-stage FSM states.
package pipeline_pkg;

    localparam logic [5:0] ALU_ADD   = 6'd0;
    localparam logic [5:0] ALU_SUB   = 6'd1;
    localparam logic [5:0] ALU_AND   = 6'd2;
    localparam logic [5:0] ALU_OR    = 6'd3;
    localparam logic [5:0] ALU_XOR   = 6'd4;
    localparam logic [5:0] ALU_SLL   = 6'd5;
    localparam logic [5:0] ALU_SRL   = 6'd6;
    localparam logic [5:0] ALU_SRA   = 6'd7;
    localparam logic [5:0] ALU_SLT   = 6'd8;
    localparam logic [5:0] ALU_SLTU  = 6'd9;
    localparam logic [5:0] ALU_PASSB = 6'd10;
    localparam logic [5:0] ALU_MUL   = 6'd11;
    localparam logic [5:0] ALU_MULH  = 6'd12;
    localparam logic [5:0] ALU_MULHU = 6'd13;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_EM  = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } ex_state_e;

    function automatic logic is_mul_op(input logic [5:0] op);
        return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHU);
    endfunction

endpackage

// File: rtl/iter_multiplier.sv
// Unsigned shift-add multiplier producing one product bit per cycle.
// Handshake: start_i loads operands (ignored while abort_i is high); done_o is
// high during the final iteration, and product_o holds the result afterwards.
module iter_multiplier
    import pipeline_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [2*XLEN-1:0] product_o
);

    localparam int CW = $clog2(MUL_CYCLES);

    logic              busy;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;
    logic [2*XLEN-1:0] acc;

    assign done_o    = busy && (count == CW'(MUL_CYCLES - 1));
    assign busy_o    = busy;
    assign product_o = acc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy   <= 1'b0;
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (abort_i) begin
            busy  <= 1'b0;
            count <= '0;
            acc   <= '0;
        end else if (start_i) begin
            busy   <= 1'b1;
            count  <= '0;
            mcand  <= {{XLEN{1'b0}}, a_i};
            mplier <= b_i;
            acc    <= '0;
        end else if (busy) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            if (done_o) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage of the 5-stage RV32 pipeline: operand forwarding, ALU, branch
// and jump resolution, and an iterative multiplier that stalls upstream.
module execute_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic [5:0]      alu_op_i,
    input  logic            alusrc1_i,
    input  logic            alusrc2_i,
    input  logic            mem_to_reg_i,
    input  logic            reg_write_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic            jump_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] read_data1_i,
    input  logic [XLEN-1:0] read_data2_i,
    input  logic [XLEN-1:0] offset_i,
    input  logic [1:0]      fwd_a_i,
    input  logic [1:0]      fwd_b_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            stall_o,
    output logic [XLEN-1:0] em_alu_result_o,
    output logic [XLEN-1:0] em_store_data_o,
    output logic [4:0]      em_rd_o,
    output logic [2:0]      em_funct3_o,
    output logic            em_mem_to_reg_o,
    output logic            em_reg_write_o,
    output logic            em_mem_read_o,
    output logic            em_mem_write_o,
    output logic            em_branch_taken_o,
    output logic [XLEN-1:0] em_branch_target_o,
    output logic [1:0]      dbg_state_o
);

    localparam int PW = 2 * XLEN;

    ex_state_e       state, state_next;
    logic [XLEN-1:0] fa, fb, op_a, op_b;
    logic [XLEN-1:0] alu_result, ex_result, br_target;
    logic            br_cond, br_taken;
    logic [4:0]      shamt;

    logic            is_mul, mul_start, mul_done, mul_busy, stall_raw;
    logic            a_neg, b_neg, mul_signed;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            mul_neg, mul_high;
    logic [PW-1:0]   mul_product, mul_fixed;
    logic [XLEN-1:0] mul_result;

    // em_alu_result_o is frozen during a multiply, so forwarding sees the held value
    always_comb begin
        case (fwd_a_i)
            FWD_EM:  fa = em_alu_result_o;
            FWD_WB:  fa = wb_data_i;
            default: fa = read_data1_i;
        endcase
        case (fwd_b_i)
            FWD_EM:  fb = em_alu_result_o;
            FWD_WB:  fb = wb_data_i;
            default: fb = read_data2_i;
        endcase
    end

    assign op_a  = alusrc1_i ? pc_i : fa;
    assign op_b  = alusrc2_i ? offset_i : fb;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_result = '0;
        case (alu_op_i)
            ALU_ADD:   alu_result = op_a + op_b;
            ALU_SUB:   alu_result = op_a - op_b;
            ALU_AND:   alu_result = op_a & op_b;
            ALU_OR:    alu_result = op_a | op_b;
            ALU_XOR:   alu_result = op_a ^ op_b;
            ALU_SLL:   alu_result = op_a << shamt;
            ALU_SRL:   alu_result = op_a >> shamt;
            ALU_SRA:   alu_result = XLEN'($signed(op_a) >>> shamt);
            ALU_SLT:   alu_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU:  alu_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_PASSB: alu_result = op_b;
            default:   alu_result = '0;
        endcase
    end

    always_comb begin
        case (funct3_i)
            F3_BEQ:  br_cond = (fa == fb);
            F3_BNE:  br_cond = (fa != fb);
            F3_BLT:  br_cond = ($signed(fa) < $signed(fb));
            F3_BGE:  br_cond = ($signed(fa) >= $signed(fb));
            F3_BLTU: br_cond = (fa < fb);
            F3_BGEU: br_cond = (fa >= fb);
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        br_taken  = 1'b0;
        br_target = pc_i + offset_i;
        ex_result = alu_result;
        if (jump_i) begin
            br_taken  = 1'b1;
            ex_result = pc_i + XLEN'(4);
            if (opcode_i == OPC_JALR) begin
                br_target = (fa + offset_i) & {{(XLEN-1){1'b1}}, 1'b0};
            end
        end else if (opcode_i == OPC_BRANCH) begin
            br_taken = br_cond;
        end
    end

    // Only MULH treats operands as signed; the multiplier always sees magnitudes
    assign is_mul     = is_mul_op(alu_op_i);
    assign mul_signed = (alu_op_i == ALU_MULH);
    assign a_neg      = mul_signed & op_a[XLEN-1];
    assign b_neg      = mul_signed & op_b[XLEN-1];
    assign a_mag      = a_neg ? (~op_a + XLEN'(1)) : op_a;
    assign b_mag      = b_neg ? (~op_b + XLEN'(1)) : op_b;
    assign mul_fixed  = mul_neg ? (~mul_product + PW'(1)) : mul_product;
    assign mul_result = mul_high ? mul_fixed[PW-1:XLEN] : mul_fixed[XLEN-1:0];

    iter_multiplier #(
        .XLEN       (XLEN),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .start_i   (mul_start),
        .abort_i   (flush_i),
        .a_i       (a_mag),
        .b_i       (b_mag),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mul_start  = 1'b0;
        stall_raw  = 1'b0;
        if (flush_i) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (valid_i && is_mul) begin
                        mul_start  = 1'b1;
                        stall_raw  = 1'b1;
                        state_next = ST_MUL;
                    end
                end
                ST_MUL: begin
                    stall_raw = 1'b1;
                    if (mul_done || !mul_busy) begin
                        state_next = ST_DONE;
                    end
                end
                ST_DONE: state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign stall_o     = stall_raw & rst_ni;
    assign dbg_state_o = state;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            em_alu_result_o    <= '0;
            em_store_data_o    <= '0;
            em_rd_o            <= '0;
            em_funct3_o        <= '0;
            em_mem_to_reg_o    <= 1'b0;
            em_reg_write_o     <= 1'b0;
            em_mem_read_o      <= 1'b0;
            em_mem_write_o     <= 1'b0;
            em_branch_taken_o  <= 1'b0;
            em_branch_target_o <= '0;
            mul_neg            <= 1'b0;
            mul_high           <= 1'b0;
        end else if (flush_i) begin
            em_mem_to_reg_o   <= 1'b0;
            em_reg_write_o    <= 1'b0;
            em_mem_read_o     <= 1'b0;
            em_mem_write_o    <= 1'b0;
            em_branch_taken_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (valid_i && is_mul) begin
                        em_mem_to_reg_o   <= 1'b0;
                        em_reg_write_o    <= 1'b0;
                        em_mem_read_o     <= 1'b0;
                        em_mem_write_o    <= 1'b0;
                        em_branch_taken_o <= 1'b0;
                        mul_neg           <= a_neg ^ b_neg;
                        mul_high          <= (alu_op_i != ALU_MUL);
                    end else begin
                        em_alu_result_o    <= ex_result;
                        em_store_data_o    <= fb;
                        em_rd_o            <= rd_i;
                        em_funct3_o        <= funct3_i;
                        em_mem_to_reg_o    <= valid_i & mem_to_reg_i;
                        em_reg_write_o     <= valid_i & reg_write_i;
                        em_mem_read_o      <= valid_i & mem_read_i;
                        em_mem_write_o     <= valid_i & mem_write_i;
                        em_branch_taken_o  <= valid_i & br_taken;
                        em_branch_target_o <= br_target;
                    end
                end
                ST_DONE: begin
                    em_alu_result_o   <= mul_result;
                    em_store_data_o   <= fb;
                    em_rd_o           <= rd_i;
                    em_funct3_o       <= funct3_i;
                    em_mem_to_reg_o   <= mem_to_reg_i;
                    em_reg_write_o    <= reg_write_i;
                    em_mem_read_o     <= mem_read_i;
                    em_mem_write_o    <= mem_write_i;
                    em_branch_taken_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: ALU, forwarding, branches, jumps,
// the iterative multiplier, flush and mid-multiply reset.
module tb_execute_stage;
    import pipeline_pkg::*;

    logic        clk_i, rst_ni, valid_i, flush_i;
    logic [31:0] pc_i;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [5:0]  alu_op_i;
    logic        alusrc1_i, alusrc2_i;
    logic        mem_to_reg_i, reg_write_i, mem_read_i, mem_write_i, jump_i;
    logic [4:0]  rd_i;
    logic [31:0] read_data1_i, read_data2_i, offset_i, wb_data_i;
    logic [1:0]  fwd_a_i, fwd_b_i;
    logic        stall_o;
    logic [31:0] em_alu_result_o, em_store_data_o, em_branch_target_o;
    logic [4:0]  em_rd_o;
    logic [2:0]  em_funct3_o;
    logic        em_mem_to_reg_o, em_reg_write_o, em_mem_read_o, em_mem_write_o;
    logic        em_branch_taken_o;
    logic [1:0]  dbg_state_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    execute_stage dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .flush_i(flush_i),
        .pc_i(pc_i), .opcode_i(opcode_i), .funct3_i(funct3_i), .alu_op_i(alu_op_i),
        .alusrc1_i(alusrc1_i), .alusrc2_i(alusrc2_i), .mem_to_reg_i(mem_to_reg_i),
        .reg_write_i(reg_write_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .jump_i(jump_i), .rd_i(rd_i), .read_data1_i(read_data1_i),
        .read_data2_i(read_data2_i), .offset_i(offset_i), .fwd_a_i(fwd_a_i),
        .fwd_b_i(fwd_b_i), .wb_data_i(wb_data_i), .stall_o(stall_o),
        .em_alu_result_o(em_alu_result_o), .em_store_data_o(em_store_data_o),
        .em_rd_o(em_rd_o), .em_funct3_o(em_funct3_o), .em_mem_to_reg_o(em_mem_to_reg_o),
        .em_reg_write_o(em_reg_write_o), .em_mem_read_o(em_mem_read_o),
        .em_mem_write_o(em_mem_write_o), .em_branch_taken_o(em_branch_taken_o),
        .em_branch_target_o(em_branch_target_o), .dbg_state_o(dbg_state_o)
    );

    // clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // reference ALU
    function automatic logic [31:0] model_alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] s;
        s = b[4:0];
        case (op)
            ALU_ADD:   return a + b;
            ALU_SUB:   return a - b;
            ALU_AND:   return a & b;
            ALU_OR:    return a | b;
            ALU_XOR:   return a ^ b;
            ALU_SLL:   return a << s;
            ALU_SRL:   return a >> s;
            ALU_SRA:   return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            ALU_SLT:   return (a[31] != b[31]) ? {31'h0, a[31]} : {31'h0, (a < b)};
            ALU_SLTU:  return {31'h0, (a < b)};
            ALU_PASSB: return b;
            default:   return 32'h0;
        endcase
    endfunction

    // driver tasks
    task automatic clear_inputs();
        valid_i = 0; flush_i = 0; pc_i = 0; opcode_i = 0; funct3_i = 0; alu_op_i = 0;
        alusrc1_i = 0; alusrc2_i = 0; mem_to_reg_i = 0; reg_write_i = 0; mem_read_i = 0;
        mem_write_i = 0; jump_i = 0; rd_i = 0; read_data1_i = 0; read_data2_i = 0;
        offset_i = 0; fwd_a_i = FWD_REG; fwd_b_i = FWD_REG; wb_data_i = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        clear_inputs();
        valid_i = 1; alu_op_i = op; read_data1_i = a; read_data2_i = b;
        reg_write_i = 1; rd_i = 5'd3; opcode_i = 7'b0110011;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_ni = 0;
        next_cycle();
        next_cycle();
        n_checks++; if (em_alu_result_o !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", em_alu_result_o); end
        n_checks++; if (em_reg_write_o !== 1'b0) begin n_fail++; $display("FAIL reset_reg_write: got %b expected 0", em_reg_write_o); end
        n_checks++; if (em_branch_taken_o !== 1'b0) begin n_fail++; $display("FAIL reset_taken: got %b expected 0", em_branch_taken_o); end
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
        n_checks++; if (dbg_state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state_o); end
        rst_ni = 1;
        next_cycle();
    endtask

    task automatic test_add();
        drive_alu(ALU_ADD, 32'd5, 32'd7);
        exp_q.push_back(32'd12);
        #1;
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL add_stall: got %b expected 0", stall_o); end
        next_cycle();
        exp_v = exp_q.pop_front();
        n_checks++; if (em_alu_result_o !== exp_v) begin n_fail++; $display("FAIL add_result: got %h expected %h", em_alu_result_o, exp_v); end
        n_checks++; if (em_reg_write_o !== 1'b1) begin n_fail++; $display("FAIL add_reg_write: got %b expected 1", em_reg_write_o); end
        n_checks++; if (em_rd_o !== 5'd3) begin n_fail++; $display("FAIL add_rd: got %0d expected 3", em_rd_o); end
    endtask

    task automatic test_wrap();
        clear_inputs();
        valid_i = 1; alu_op_i = ALU_ADD; fwd_a_i = FWD_WB; wb_data_i = 32'hFFFF_FFFF;
        read_data1_i = 32'd123; alusrc2_i = 1; offset_i = 32'd1; reg_write_i = 1;
        exp_q.push_back(32'h0);
        next_cycle();
        exp_v = exp_q.pop_front();
        n_checks++; if (em_alu_result_o !== exp_v) begin n_fail++; $display("FAIL wrap_result: got %h expected %h", em_alu_result_o, exp_v); end
    endtask

    task automatic test_branch();
        logic [2:0] f3s[4];
        logic       taken[4];
        f3s = '{F3_BLT, F3_BLTU, F3_BGE, F3_BGEU};
        taken = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            valid_i = 1; opcode_i = OPC_BRANCH; funct3_i = f3s[i];
            read_data1_i = 32'hFFFF_FFFE; read_data2_i = 32'd1; pc_i = 32'h100; offset_i = 32'h20;
            next_cycle();
            n_checks++; if (em_branch_taken_o !== taken[i]) begin n_fail++; $display("FAIL branch_taken_%0d: got %b expected %b", i, em_branch_taken_o, taken[i]); end
            if (taken[i]) begin
                n_checks++; if (em_branch_target_o !== 32'h120) begin n_fail++; $display("FAIL branch_target_%0d: got %h expected 120", i, em_branch_target_o); end
            end
        end
    endtask

    task automatic test_jump();
        clear_inputs();
        valid_i = 1; jump_i = 1; opcode_i = OPC_JALR; read_data1_i = 32'h1001;
        offset_i = 32'h10; pc_i = 32'h200; reg_write_i = 1;
        exp_q.push_back(32'h204);
        next_cycle();
        exp_v = exp_q.pop_front();
        n_checks++; if (em_alu_result_o !== exp_v) begin n_fail++; $display("FAIL jalr_link: got %h expected %h", em_alu_result_o, exp_v); end
        n_checks++; if (em_branch_taken_o !== 1'b1) begin n_fail++; $display("FAIL jalr_taken: got %b expected 1", em_branch_taken_o); end
        n_checks++; if (em_branch_target_o !== 32'h1010) begin n_fail++; $display("FAIL jalr_target: got %h expected 1010", em_branch_target_o); end
        opcode_i = 7'b1101111; offset_i = 32'h40;
        next_cycle();
        n_checks++; if (em_branch_target_o !== 32'h240) begin n_fail++; $display("FAIL jal_target: got %h expected 240", em_branch_target_o); end
    endtask

    task automatic test_alu_random();
        logic [5:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 16; i++) begin
            op = (i == 15) ? 6'd40 : 6'($urandom_range(0, 10));
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            drive_alu(op, a, b);
            exp_q.push_back(model_alu(op, a, b));
            next_cycle();
            exp_v = exp_q.pop_front();
            n_checks++; if (em_alu_result_o !== exp_v) begin n_fail++; $display("FAIL alu_rand op=%0d a=%h b=%h: got %h expected %h", op, a, b, em_alu_result_o, exp_v); end
        end
    endtask

    task automatic test_mul();
        logic [5:0]         ops[4];
        logic [31:0]        as[4], bs[4];
        logic signed [63:0] sp;
        logic [63:0]        up;
        int                 cnt;
        ops = '{ALU_MULH, ALU_MUL, ALU_MULHU, ALU_MULH};
        as  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, $urandom};
        bs  = '{32'd2, 32'd2, 32'd2, $urandom};
        for (int i = 0; i < 4; i++) begin
            drive_alu(ops[i], as[i], bs[i]);
            rd_i = 5'd7;
            sp = $signed({{32{as[i][31]}}, as[i]}) * $signed({{32{bs[i][31]}}, bs[i]});
            up = {32'h0, as[i]} * {32'h0, bs[i]};
            if (ops[i] == ALU_MULH)       exp_q.push_back(sp[63:32]);
            else if (ops[i] == ALU_MULHU) exp_q.push_back(up[63:32]);
            else                          exp_q.push_back(up[31:0]);
            #1;
            cnt = 0;
            while (stall_o === 1'b1 && cnt < 100) begin
                cnt++;
                if (cnt == 2) begin
                    n_checks++; if (em_reg_write_o !== 1'b0) begin n_fail++; $display("FAIL mul_bubble_%0d: got %b expected 0", i, em_reg_write_o); end
                end
                next_cycle();
            end
            n_checks++; if (cnt !== 33) begin n_fail++; $display("FAIL mul_stall_cycles_%0d: got %0d expected 33", i, cnt); end
            next_cycle();
            exp_v = exp_q.pop_front();
            n_checks++; if (em_alu_result_o !== exp_v) begin n_fail++; $display("FAIL mul_result_%0d: got %h expected %h", i, em_alu_result_o, exp_v); end
            n_checks++; if (em_reg_write_o !== 1'b1 || em_rd_o !== 5'd7) begin n_fail++; $display("FAIL mul_writeback_%0d: got we=%b rd=%0d expected we=1 rd=7", i, em_reg_write_o, em_rd_o); end
            clear_inputs();
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        int cnt;
        drive_alu(ALU_MUL, 32'd3, 32'd4);
        exp_q.push_back(32'd12);
        #1;
        cnt = 0;
        while (stall_o === 1'b1 && cnt < 100) begin cnt++; next_cycle(); end
        next_cycle();
        exp_v = exp_q.pop_front();
        n_checks++; if (em_alu_result_o !== exp_v) begin n_fail++; $display("FAIL b2b_mul: got %h expected %h", em_alu_result_o, exp_v); end
        drive_alu(ALU_ADD, 32'd0, 32'd1);
        fwd_a_i = FWD_EM;
        exp_q.push_back(32'd13);
        #1;
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL b2b_stall: got %b expected 0", stall_o); end
        next_cycle();
        exp_v = exp_q.pop_front();
        n_checks++; if (em_alu_result_o !== exp_v) begin n_fail++; $display("FAIL b2b_add_fwd: got %h expected %h", em_alu_result_o, exp_v); end
    endtask

    task automatic test_flush();
        drive_alu(ALU_MUL, 32'd7, 32'd9);
        for (int i = 0; i < 11; i++) next_cycle();
        flush_i = 1;
        #1;
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b expected 0", stall_o); end
        next_cycle();
        n_checks++; if (em_reg_write_o !== 1'b0) begin n_fail++; $display("FAIL flush_reg_write: got %b expected 0", em_reg_write_o); end
        n_checks++; if (dbg_state_o !== 2'd0) begin n_fail++; $display("FAIL flush_state: got %0d expected 0", dbg_state_o); end
        drive_alu(ALU_ADD, 32'd2, 32'd3);
        exp_q.push_back(32'd5);
        #1;
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL flush_add_stall: got %b expected 0", stall_o); end
        next_cycle();
        exp_v = exp_q.pop_front();
        n_checks++; if (em_alu_result_o !== exp_v) begin n_fail++; $display("FAIL flush_add_result: got %h expected %h", em_alu_result_o, exp_v); end
    endtask

    task automatic test_reset_mid_mul();
        drive_alu(ALU_MULHU, 32'hFFFF_FFFF, 32'd2);
        for (int i = 0; i < 6; i++) next_cycle();
        rst_ni = 0;
        #1;
        n_checks++; if (em_alu_result_o !== 32'h0) begin n_fail++; $display("FAIL rstmid_result: got %h expected 0", em_alu_result_o); end
        n_checks++; if (em_reg_write_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_reg_write: got %b expected 0", em_reg_write_o); end
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall: got %b expected 0", stall_o); end
        n_checks++; if (dbg_state_o !== 2'd0) begin n_fail++; $display("FAIL rstmid_state: got %0d expected 0", dbg_state_o); end
        clear_inputs();
        next_cycle();
        rst_ni = 1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            n_checks++; if (em_reg_write_o !== 1'b0 || em_mem_write_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_bubble_%0d: got we=%b mw=%b expected 0", i, em_reg_write_o, em_mem_write_o); end
        end
    endtask

    initial begin
        clear_inputs();
        rst_ni = 0;
        test_reset();
        test_add();
        test_wrap();
        test_branch();
        test_jump();
        test_alu_random();
        test_mul();
        test_back_to_back();
        test_flush();
        test_reset_mid_mul();
        n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
